// File: rtl/apb_splitter_tmo_pkg.sv
// Shared definitions for the registered APB splitter: FSM state encoding and
// the timeout counter width helper.
package apb_splitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Counter must hold TIMEOUT-1 and still be at least one bit wide when disabled.
    function automatic int unsigned cnt_width(input int unsigned tmo);
        int unsigned w;
        w = $clog2(tmo + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_splitter_tmo_if.sv
// Upstream APB slave port plus the broadcast/per-lane downstream APB master
// ports of the splitter, bundled as one interface.
interface apb_splitter_tmo_if #(
    parameter int unsigned W_ADDR   = 16,
    parameter int unsigned W_DATA   = 32,
    parameter int unsigned N_SLAVES = 3
);
    logic [W_ADDR-1:0]          apbs_paddr;
    logic [W_DATA-1:0]          apbs_pwdata;
    logic                       apbs_psel;
    logic                       apbs_penable;
    logic                       apbs_pwrite;
    logic [W_DATA-1:0]          apbs_phartid;
    logic [W_ADDR-1:0]          apbs_pd_pc;
    logic                       apbs_pready;
    logic                       apbs_pslverr;
    logic [W_DATA-1:0]          apbs_prdata;

    logic [N_SLAVES*W_ADDR-1:0] apbm_paddr;
    logic [N_SLAVES*W_DATA-1:0] apbm_pwdata;
    logic [N_SLAVES-1:0]        apbm_psel;
    logic [N_SLAVES-1:0]        apbm_penable;
    logic [N_SLAVES-1:0]        apbm_pwrite;
    logic [N_SLAVES-1:0]        apbm_pready;
    logic [N_SLAVES-1:0]        apbm_pslverr;
    logic [N_SLAVES*W_DATA-1:0] apbm_prdata;
    logic [N_SLAVES*W_DATA-1:0] apbm_hartid;
    logic [N_SLAVES*W_ADDR-1:0] apbm_pd_pc;

    // Splitter side: upstream slave, downstream masters.
    modport slave (
        input  apbs_paddr, apbs_pwdata, apbs_psel, apbs_penable, apbs_pwrite,
        input  apbs_phartid, apbs_pd_pc,
        output apbs_pready, apbs_pslverr, apbs_prdata,
        output apbm_paddr, apbm_pwdata, apbm_psel, apbm_penable, apbm_pwrite,
        output apbm_hartid, apbm_pd_pc,
        input  apbm_pready, apbm_pslverr, apbm_prdata
    );

    // Environment side: upstream requester and downstream peripherals.
    modport master (
        output apbs_paddr, apbs_pwdata, apbs_psel, apbs_penable, apbs_pwrite,
        output apbs_phartid, apbs_pd_pc,
        input  apbs_pready, apbs_pslverr, apbs_prdata,
        input  apbm_paddr, apbm_pwdata, apbm_psel, apbm_penable, apbm_pwrite,
        input  apbm_hartid, apbm_pd_pc,
        output apbm_pready, apbm_pslverr, apbm_prdata
    );

endinterface

// File: rtl/apb_splitter_tmo_addr_decode.sv
// Window decoder: flags a hit and returns the lowest-index matching window
// as a one-hot vector.
module apb_addr_decode #(
    parameter int unsigned                   W_ADDR    = 16,
    parameter int unsigned                   N_SLAVES  = 3,
    parameter logic [N_SLAVES*W_ADDR-1:0]    ADDR_MAP  = 48'h4000_2000_0000,
    parameter logic [N_SLAVES*W_ADDR-1:0]    ADDR_MASK = 48'he000_e000_e000
) (
    input  logic [W_ADDR-1:0]   paddr,
    output logic                hit,
    output logic [N_SLAVES-1:0] sel
);

    always_comb begin
        hit = 1'b0;
        sel = '0;
        // Once a window has matched, higher indices are ignored.
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (!hit &&
                ((paddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR])) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_mux.sv
// AND-OR multiplexer selecting one W-bit lane out of N with a one-hot select.
module onehot_mux #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 32
) (
    input  logic [N-1:0]   sel,
    input  logic [N*W-1:0] din,
    output logic [W-1:0]   dout
);

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel[i]) dout |= din[i*W +: W];
        end
    end

endmodule

// File: rtl/apb_splitter_tmo.sv
// Registered APB splitter with priority window decode, unmapped-address error
// response and a per-transfer ACCESS timeout.
module apb_splitter_tmo
    import apb_splitter_pkg::*;
#(
    parameter int unsigned                W_ADDR    = 16,
    parameter int unsigned                W_DATA    = 32,
    parameter int unsigned                N_SLAVES  = 3,
    parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MAP  = 48'h4000_2000_0000,
    parameter logic [N_SLAVES*W_ADDR-1:0] ADDR_MASK = 48'he000_e000_e000,
    parameter int unsigned                TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    apb_splitter_tmo_if.slave  bus
);

    localparam int unsigned           CNT_W    = cnt_width(TIMEOUT);
    localparam bit                    TMO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0]      TMO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [W_ADDR-1:0]     addr_q, addr_d;
    logic [W_DATA-1:0]     wdata_q, wdata_d;
    logic [W_DATA-1:0]     hartid_q, hartid_d;
    logic [W_ADDR-1:0]     pd_pc_q, pd_pc_d;
    logic                  pwrite_q, pwrite_d;
    logic [N_SLAVES-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_SLAVES-1:0]   mpsel_q, mpsel_d;
    logic [N_SLAVES-1:0]   mpen_q, mpen_d;
    logic [N_SLAVES-1:0]   mpwr_q, mpwr_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [W_DATA-1:0]     prdata_q, prdata_d;

    logic                  dec_hit;
    logic [N_SLAVES-1:0]   dec_sel;
    logic [W_DATA-1:0]     mux_rdata;
    logic                  accept;
    logic                  sel_ready;
    logic                  sel_err;
    logic                  active;

    apb_addr_decode #(
        .W_ADDR    (W_ADDR),
        .N_SLAVES  (N_SLAVES),
        .ADDR_MAP  (ADDR_MAP),
        .ADDR_MASK (ADDR_MASK)
    ) u_decode (
        .paddr (bus.apbs_paddr),
        .hit   (dec_hit),
        .sel   (dec_sel)
    );

    onehot_mux #(
        .N (N_SLAVES),
        .W (W_DATA)
    ) u_rdata_mux (
        .sel  (sel_q),
        .din  (bus.apbm_prdata),
        .dout (mux_rdata)
    );

    assign accept    = (state_q == ST_IDLE) && bus.apbs_psel && !bus.apbs_penable;
    assign sel_ready = |(bus.apbm_pready & sel_q);
    assign sel_err   = |(bus.apbm_pslverr & sel_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            hartid_q  <= '0;
            pd_pc_q   <= '0;
            pwrite_q  <= 1'b0;
            sel_q     <= '0;
            cnt_q     <= '0;
            mpsel_q   <= '0;
            mpen_q    <= '0;
            mpwr_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            hartid_q  <= hartid_d;
            pd_pc_q   <= pd_pc_d;
            pwrite_q  <= pwrite_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            mpsel_q   <= mpsel_d;
            mpen_q    <= mpen_d;
            mpwr_q    <= mpwr_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = dec_hit ? ST_SETUP : ST_RESP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                // A ready slave wins over a timeout expiring in the same cycle.
                if (sel_ready)                          state_d = ST_RESP;
                else if (TMO_EN && (cnt_q == TMO_LAST)) state_d = ST_RESP;
            end
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin : outputs
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hartid_d = hartid_q;
        pd_pc_d  = pd_pc_q;
        pwrite_d = pwrite_q;
        sel_d    = sel_q;
        if (accept) begin
            addr_d   = bus.apbs_paddr;
            wdata_d  = bus.apbs_pwdata;
            hartid_d = bus.apbs_phartid;
            pd_pc_d  = bus.apbs_pd_pc;
            pwrite_d = bus.apbs_pwrite;
            sel_d    = dec_sel;
        end

        cnt_d = '0;
        if (state_q == ST_ACCESS) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        // Lane strobes are registered from the next state so they line up with it.
        active  = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        mpsel_d = active ? sel_d : '0;
        mpen_d  = (state_d == ST_ACCESS) ? sel_d : '0;
        mpwr_d  = (active && pwrite_d) ? sel_d : '0;

        pready_d  = (state_d == ST_RESP);
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (state_d == ST_RESP) begin
            if ((state_q == ST_ACCESS) && sel_ready) begin
                prdata_d  = mux_rdata;
                pslverr_d = sel_err;
            end else begin
                pslverr_d = 1'b1;
            end
        end
    end

    assign bus.apbs_pready  = pready_q;
    assign bus.apbs_pslverr = pslverr_q;
    assign bus.apbs_prdata  = prdata_q;
    assign bus.apbm_psel    = mpsel_q;
    assign bus.apbm_penable = mpen_q;
    assign bus.apbm_pwrite  = mpwr_q;
    assign bus.apbm_paddr   = {N_SLAVES{addr_q}};
    assign bus.apbm_pwdata  = {N_SLAVES{wdata_q}};
    assign bus.apbm_hartid  = {N_SLAVES{hartid_q}};
    assign bus.apbm_pd_pc   = {N_SLAVES{pd_pc_q}};

endmodule
